int_exec_unit: RTL
==================

INT_EXEC_UNIT -- requirements
Module: int_exec_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 The module SHALL have parameter TAG_W, default 6, width of the opaque instruction tag carried alongside each operation.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port flush  input  1  synchronous kill of all in-flight operations.
REQ-006 Port in_valid  input  1  upstream offers an operation.
REQ-007 Port in_ready  output  1  unit accepts the operation this cycle.
REQ-008 Port in_sel  input  5  operation select (encoding per REQ-016).
REQ-009 Port in_op1, in_op2  input  XLEN  operands; for AUIPC, op1 is the PC and op2[19:0] is the immediate.
REQ-010 Port in_tag  input  TAG_W  tag returned with the result.
REQ-011 Port out_valid  output  1  result available.
REQ-012 Port out_ready  input  1  downstream accepts the result.
REQ-013 Port out_result  output  XLEN  operation result.
REQ-014 Port out_tag  output  TAG_W  tag of the returned result.
REQ-015 Port out_illegal  output  1  select code unsupported for this XLEN.

Function
REQ-016 Encoding SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 AUIPC, 11 LUI, 12 ADDW, 13 SUBW, 14 SLLW, 15 SRLW, 16 SRAW; 17-31 illegal.
REQ-017 The pipeline SHALL have two stages: S1 (operand register), then S2 (result register); an accepted operation appears on out_* exactly 2 cycles after acceptance if out_ready stays high.
REQ-018 A transfer SHALL occur on each side only when valid and ready are both high on the same rising edge.
REQ-019 in_ready SHALL equal !S1_valid || S1 advancing, where S1 advances when !S2_valid || out_ready.
REQ-020 Sustained throughput SHALL be one operation per cycle when out_ready is held high.
REQ-021 While out_valid is high and out_ready is low, out_result, out_tag and out_illegal SHALL hold stable.
REQ-022 SUB SHALL compute op1 + ~op2 + 1 on the full XLEN width; ADD, SUB and AUIPC SHALL wrap modulo 2^XLEN.
REQ-023 AUIPC SHALL return op1 + sext(op2[19:0] << 12); LUI SHALL return sext(op2[19:0] << 12).
REQ-024 SLL, SRL and SRA SHALL use shift amount op2[log2(XLEN)-1:0]; SRA SHALL replicate op1[XLEN-1].
REQ-025 SLT and SLTU SHALL return 1 or 0 zero-extended to XLEN, using a signed and an unsigned compare respectively.
REQ-026 W ops SHALL operate on op1[31:0] and op2[31:0], use shift amount op2[4:0], and sign-extend the 32-bit result from bit 31 to XLEN.
REQ-027 With XLEN=32, codes 12-16 SHALL be illegal.
REQ-028 An illegal code SHALL flow through the pipeline with normal latency, giving out_result=0 and out_illegal=1; no other output is affected.
REQ-029 flush SHALL clear S1_valid and S2_valid at the next edge, take priority over a simultaneous accept (the offered operation is dropped), and force in_ready low that cycle.
REQ-030 A result being transferred on the same edge as flush SHALL still count as delivered.

Reset
REQ-031 While rst is high, S1_valid, S2_valid and out_valid SHALL be 0, and out_result, out_tag and out_illegal SHALL be 0, independent of clk.
REQ-032 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-033 Assertion of rst mid-operation SHALL discard all in-flight operations without producing an output transfer.

Verification
REQ-034 Scenario: XLEN=64, SUB with op1=0, op2=1, tag=5 -> after 2 cycles, out_result=0xFFFF_FFFF_FFFF_FFFF, out_tag=5, out_illegal=0.
REQ-035 Scenario: SRAW with op1=0x0000_0000_8000_0000, op2=4 -> out_result=0xFFFF_FFFF_F800_0000; with XLEN=32, SRAW -> out_illegal=1, out_result=0.
REQ-036 Scenario: AUIPC with op1=0x1000, op2=0x80000 -> out_result=0xFFFF_FFFF_8000_1000; SLTU with op1=1, op2=-1 -> 1; SLT with the same operands -> 0.
REQ-037 Scenario: 4 back-to-back ADDs, out_ready held low for 3 cycles -> in_ready drops after 2 accepts, outputs remain stable, and all 4 results emerge in order with no loss or duplication.
REQ-038 Scenario: flush asserted with both stages full and in_valid high -> the next cycle has out_valid=0, and the offered operation is never output.
REQ-039 Scenario: rst pulsed asynchronously between edges with S2 full -> out_valid falls immediately, and in_ready=1 in the cycle after rst deasserts.

Source files
------------

// File: rtl/int_exec_unit.sv
// Two-stage integer execution unit: S1 registers operands, S2 registers the result.
// Valid/ready handshake on both sides with synchronous flush.
module int_exec_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_sel,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [XLEN-1:0] One = XLEN'(1);

  localparam logic [4:0] OpAdd   = 5'd0;
  localparam logic [4:0] OpSub   = 5'd1;
  localparam logic [4:0] OpSll   = 5'd2;
  localparam logic [4:0] OpSlt   = 5'd3;
  localparam logic [4:0] OpSltu  = 5'd4;
  localparam logic [4:0] OpXor   = 5'd5;
  localparam logic [4:0] OpSrl   = 5'd6;
  localparam logic [4:0] OpSra   = 5'd7;
  localparam logic [4:0] OpOr    = 5'd8;
  localparam logic [4:0] OpAnd   = 5'd9;
  localparam logic [4:0] OpAuipc = 5'd10;
  localparam logic [4:0] OpLui   = 5'd11;
  localparam logic [4:0] OpAddw  = 5'd12;
  localparam logic [4:0] OpSubw  = 5'd13;
  localparam logic [4:0] OpSllw  = 5'd14;
  localparam logic [4:0] OpSrlw  = 5'd15;
  localparam logic [4:0] OpSraw  = 5'd16;

  logic             r_s1_valid;
  logic [4:0]       r_s1_sel;
  logic [XLEN-1:0]  r_s1_op1;
  logic [XLEN-1:0]  r_s1_op2;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_illegal;

  logic             w_s2_adv;
  logic [ShW-1:0]   w_shamt;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic [31:0]      w_w32;
  logic [XLEN-1:0]  w_wext;
  logic [XLEN-1:0]  w_result;
  logic             w_illegal;

  // S1 advances whenever S2 can take its contents.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !flush && (!r_s1_valid || w_s2_adv);

  assign w_shamt = r_s1_op2[ShW-1:0];
  assign w_imm32 = {r_s1_op2[19:0], 12'h000};

  if (XLEN > 32) begin : g_sext
    assign w_imm  = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    assign w_wext = {{(XLEN-32){w_w32[31]}}, w_w32};
  end else begin : g_nosext
    assign w_imm  = w_imm32;
    assign w_wext = w_w32;
  end

  always_comb begin
    w_w32 = r_s1_op1[31:0] + r_s1_op2[31:0];
    case (r_s1_sel)
      OpSubw:  w_w32 = r_s1_op1[31:0] + ~r_s1_op2[31:0] + 32'd1;
      OpSllw:  w_w32 = r_s1_op1[31:0] << r_s1_op2[4:0];
      OpSrlw:  w_w32 = r_s1_op1[31:0] >> r_s1_op2[4:0];
      OpSraw:  w_w32 = $signed(r_s1_op1[31:0]) >>> r_s1_op2[4:0];
      default: w_w32 = r_s1_op1[31:0] + r_s1_op2[31:0];
    endcase
  end

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (r_s1_sel)
      OpAdd:   w_result = r_s1_op1 + r_s1_op2;
      OpSub:   w_result = r_s1_op1 + ~r_s1_op2 + One;
      OpSll:   w_result = r_s1_op1 << w_shamt;
      OpSlt:   w_result = {{(XLEN-1){1'b0}}, ($signed(r_s1_op1) < $signed(r_s1_op2))};
      OpSltu:  w_result = {{(XLEN-1){1'b0}}, (r_s1_op1 < r_s1_op2)};
      OpXor:   w_result = r_s1_op1 ^ r_s1_op2;
      OpSrl:   w_result = r_s1_op1 >> w_shamt;
      OpSra:   w_result = $signed(r_s1_op1) >>> w_shamt;
      OpOr:    w_result = r_s1_op1 | r_s1_op2;
      OpAnd:   w_result = r_s1_op1 & r_s1_op2;
      OpAuipc: w_result = r_s1_op1 + w_imm;
      OpLui:   w_result = w_imm;
      OpAddw, OpSubw, OpSllw, OpSrlw, OpSraw: begin
        if (XLEN == 64) w_result = w_wext;
        else            w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= '0;
      r_s1_op1   <= '0;
      r_s1_op2   <= '0;
      r_s1_tag   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sel <= in_sel;
        r_s1_op1 <= in_op1;
        r_s1_op2 <= in_op2;
        r_s1_tag <= in_tag;
      end
    end
  end

  // Result fields only load alongside a valid op, so they hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_tag     <= '0;
      r_s2_illegal <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result  <= w_result;
        r_s2_tag     <= r_s1_tag;
        r_s2_illegal <= w_illegal;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_tag     = r_s2_tag;
  assign out_illegal = r_s2_illegal;

endmodule
